dmem_axi_master: RTL and testbench

Sequencer between the CPU data-memory port (Master 1) and the AXI interconnect. Converts the core's level-style `dmem_ren`/`dmem_wen` requests into single-beat AXI4 read or write transactions. Drives the core's `global_stall_en` until each transaction completes. Returns load data to the WB bypass path.

---
 rtl/dmem_axi_master.sv | 184 ++++++++++++++++++
 tb/tb_dmem_axi_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : dmem_axi_master
// Description : Turns level-style CPU data-memory requests into single-beat
//               AXI4 reads/writes and stalls the pipeline until completion.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_axi_master #(
    parameter int XLEN          = 32,
    parameter int AXI_ID_BITS   = 4,
    parameter int AXI_DATA_BITS = 32,
    parameter int MASTER_ID     = 1
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    input  logic [XLEN-1:0]            dmem_addr,
    input  logic                       dmem_ren,
    input  logic                       dmem_wen,
    input  logic [AXI_DATA_BITS/8-1:0] dmem_wstrb,
    input  logic [XLEN-1:0]            dmem_wdata,
    output logic [XLEN-1:0]            dmem_rdata,
    output logic                       stall_o,
    output logic                       err_o,
    output logic [AXI_ID_BITS-1:0]     ARID,
    output logic [XLEN-1:0]            ARADDR,
    output logic [3:0]                 ARLEN,
    output logic [2:0]                 ARSIZE,
    output logic [1:0]                 ARBURST,
    output logic                       ARVALID,
    input  logic                       ARREADY,
    input  logic [AXI_ID_BITS-1:0]     RID,
    input  logic [XLEN-1:0]            RDATA,
    input  logic [1:0]                 RRESP,
    input  logic                       RLAST,
    input  logic                       RVALID,
    output logic                       RREADY,
    output logic [AXI_ID_BITS-1:0]     AWID,
    output logic [XLEN-1:0]            AWADDR,
    output logic [3:0]                 AWLEN,
    output logic [2:0]                 AWSIZE,
    output logic [1:0]                 AWBURST,
    output logic                       AWVALID,
    input  logic                       AWREADY,
    output logic [XLEN-1:0]            WDATA,
    output logic [AXI_DATA_BITS/8-1:0] WSTRB,
    output logic                       WLAST,
    output logic                       WVALID,
    input  logic                       WREADY,
    input  logic [AXI_ID_BITS-1:0]     BID,
    input  logic [1:0]                 BRESP,
    input  logic                       BVALID,
    output logic                       BREADY
);

    localparam logic [AXI_ID_BITS-1:0] C_ID = AXI_ID_BITS'(MASTER_ID);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic [XLEN-1:0]            r_addr;
    logic [XLEN-1:0]            r_wdata;
    logic [AXI_DATA_BITS/8-1:0] r_wstrb;
    logic [XLEN-1:0]            r_rdata;
    logic                       r_err;
    logic                       r_arvalid;
    logic                       r_rready;
    logic                       r_awvalid;
    logic                       r_wvalid;
    logic                       r_bready;
    logic                       r_aw_done;
    logic                       r_w_done;
    logic                       w_aw_done_nxt;
    logic                       w_w_done_nxt;
    logic                       w_unused_axi;

    // IDs and RLAST are not checked for single-beat transfers
    assign w_unused_axi = ^{RID, BID, RLAST};

    always_comb begin
        w_next        = r_state;
        w_aw_done_nxt = r_aw_done | (r_awvalid & AWREADY);
        w_w_done_nxt  = r_w_done  | (r_wvalid  & WREADY);
        case (r_state)
            S_IDLE: begin
                if (dmem_wen)      w_next = S_WR_REQ;
                else if (dmem_ren) w_next = S_RD_ADDR;
            end
            S_RD_ADDR: if (r_arvalid & ARREADY) w_next = S_RD_DATA;
            S_RD_DATA: if (r_rready & RVALID)   w_next = S_DONE;
            S_WR_REQ:  if (w_aw_done_nxt & w_w_done_nxt) w_next = S_WR_RESP;
            S_WR_RESP: if (r_bready & BVALID)   w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Handshake outputs are registered from the next state so none of them
    // depends combinationally on an AXI input.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state   <= S_IDLE;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_arvalid <= (w_next == S_RD_ADDR);
            r_rready  <= (w_next == S_RD_DATA);
            r_bready  <= (w_next == S_WR_RESP);
            r_awvalid <= (w_next == S_WR_REQ) && !w_aw_done_nxt;
            r_wvalid  <= (w_next == S_WR_REQ) && !w_w_done_nxt;
            r_aw_done <= (w_next == S_WR_REQ) && w_aw_done_nxt;
            r_w_done  <= (w_next == S_WR_REQ) && w_w_done_nxt;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                if (dmem_wen) begin
                    r_addr  <= dmem_addr;
                    r_wdata <= dmem_wdata;
                    r_wstrb <= dmem_wstrb;
                end else if (dmem_ren) begin
                    r_addr  <= dmem_addr;
                end
            end
            if ((r_state == S_RD_DATA) && r_rready && RVALID) begin
                r_rdata <= RDATA;
                if (RRESP != 2'b00) r_err <= 1'b1;
            end
            if ((r_state == S_WR_RESP) && r_bready && BVALID && (BRESP != 2'b00))
                r_err <= 1'b1;
        end
    end

    // The request cycle itself stalls; DONE releases the pipeline for one cycle.
    assign stall_o = ((r_state == S_IDLE) && (dmem_ren || dmem_wen)) ||
                     (r_state == S_RD_ADDR) || (r_state == S_RD_DATA) ||
                     (r_state == S_WR_REQ)  || (r_state == S_WR_RESP);

    assign dmem_rdata = r_rdata;
    assign err_o      = r_err;

    assign ARID    = C_ID;
    assign ARADDR  = r_addr;
    assign ARLEN   = 4'd0;
    assign ARSIZE  = 3'b010;
    assign ARBURST = 2'b01;
    assign ARVALID = r_arvalid;
    assign RREADY  = r_rready;

    assign AWID    = C_ID;
    assign AWADDR  = r_addr;
    assign AWLEN   = 4'd0;
    assign AWSIZE  = 3'b010;
    assign AWBURST = 2'b01;
    assign AWVALID = r_awvalid;
    assign WDATA   = r_wdata;
    assign WSTRB   = r_wstrb;
    assign WLAST   = 1'b1;
    assign WVALID  = r_wvalid;
    assign BREADY  = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_dmem_axi_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_axi_master
// Description : Directed self-checking bench for dmem_axi_master with a small
//               delay-programmable AXI slave.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_axi_master;

    logic        ACLK, ARESETn;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ren, dmem_wen, stall_o, err_o;
    logic [3:0]  dmem_wstrb;
    logic [3:0]  ARID, RID, AWID, BID;
    logic [31:0] ARADDR, RDATA, AWADDR, WDATA;
    logic [3:0]  ARLEN, AWLEN, WSTRB;
    logic [2:0]  ARSIZE, AWSIZE;
    logic [1:0]  ARBURST, AWBURST, RRESP, BRESP;
    logic        ARVALID, ARREADY, RLAST, RVALID, RREADY;
    logic        AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;

    int checks = 0;
    int errors = 0;

    // slave controls
    int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
    logic [31:0] s_rdata = 32'h0;
    logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;

    int   ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic r_pend, b_pend, aw_got, w_got;
    int   cyc = 0, ar_hs = 0, aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs_cyc = 0;
    logic aw_fin, w_fin;

    dmem_axi_master #(.XLEN(32), .AXI_ID_BITS(4), .AXI_DATA_BITS(32), .MASTER_ID(1)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .dmem_addr(dmem_addr), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .stall_o(stall_o), .err_o(err_o),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    assign ARREADY = ARVALID && (ar_cnt >= ar_delay);
    assign RVALID  = r_pend && (r_cnt >= r_delay);
    assign AWREADY = AWVALID && (aw_cnt >= aw_delay);
    assign WREADY  = WVALID && (w_cnt >= w_delay);
    assign BVALID  = b_pend && (b_cnt >= b_delay);
    assign RDATA   = s_rdata;
    assign RRESP   = s_rresp;
    assign BRESP   = s_bresp;
    assign RID     = 4'd1;
    assign BID     = 4'd1;
    assign RLAST   = 1'b1;
    assign aw_fin  = aw_got || (AWVALID && AWREADY);
    assign w_fin   = w_got || (WVALID && WREADY);

    always @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            r_pend <= 1'b0; b_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0;
        end else begin
            if (ARVALID && ARREADY) begin ar_cnt <= 0; r_pend <= 1'b1; end
            else if (ARVALID) ar_cnt <= ar_cnt + 1;
            if (RVALID && RREADY) begin r_pend <= 1'b0; r_cnt <= 0; end
            else if (r_pend) r_cnt <= r_cnt + 1;
            if (AWVALID && AWREADY) aw_cnt <= 0; else if (AWVALID) aw_cnt <= aw_cnt + 1;
            if (WVALID && WREADY) w_cnt <= 0; else if (WVALID) w_cnt <= w_cnt + 1;
            if (BVALID && BREADY) begin b_pend <= 1'b0; b_cnt <= 0; end
            else if (b_pend) b_cnt <= b_cnt + 1;
            if (aw_fin && w_fin) begin b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0; end
            else begin aw_got <= aw_fin; w_got <= w_fin; end
        end
    end

    always @(posedge ACLK) begin
        cyc <= cyc + 1;
        if (ARVALID && ARREADY) begin ar_hs <= ar_hs + 1; ar_hs_cyc <= cyc; end
        if (AWVALID && AWREADY) aw_hs <= aw_hs + 1;
        if (WVALID && WREADY) w_hs <= w_hs + 1;
        if (BVALID && BREADY) b_hs <= b_hs + 1;
    end

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
        dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        repeat (2) step();
        checks++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY} !== 5'b0) begin errors++; $display("FAIL reset_handshakes got %b expected 00000", {ARVALID, RREADY, AWVALID, WVALID, BREADY}); end
        checks++; if (dmem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", dmem_rdata); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL reset_err got %b expected 0", err_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall_idle got %b expected 0", stall_o); end
        dmem_ren = 1'b1; #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL reset_stall_req got %b expected 1", stall_o); end
        dmem_ren = 1'b0;
        step();
        ARESETn = 1'b1;
        step();
    endtask

    task automatic test_load();
        int a0;
        a0 = ar_hs;
        s_rdata = 32'hDEAD_BEEF; dmem_addr = 32'h0000_1004; dmem_ren = 1'b1;
        #1;
        checks++; if ({stall_o, ARVALID} !== 2'b10) begin errors++; $display("FAIL load_c0 stall/arvalid got %b expected 10", {stall_o, ARVALID}); end
        step();
        checks++; if ({stall_o, ARVALID, ARLEN, ARSIZE, ARBURST, ARID} !== {1'b1, 1'b1, 4'd0, 3'd2, 2'b01, 4'd1}) begin errors++; $display("FAIL load_c1 ar fields got %b", {stall_o, ARVALID, ARLEN, ARSIZE, ARBURST, ARID}); end
        checks++; if (ARADDR !== 32'h0000_1004) begin errors++; $display("FAIL load_araddr got %h expected 00001004", ARADDR); end
        step();
        checks++; if ({stall_o, ARVALID, RREADY} !== 3'b101) begin errors++; $display("FAIL load_c2 stall/arvalid/rready got %b expected 101", {stall_o, ARVALID, RREADY}); end
        step();
        checks++; if ({stall_o, RREADY} !== 2'b00) begin errors++; $display("FAIL load_c3 stall/rready got %b expected 00", {stall_o, RREADY}); end
        checks++; if (dmem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h expected deadbeef", dmem_rdata); end
        dmem_ren = 1'b0;
        step();
        checks++; if ((ar_hs - a0) !== 1) begin errors++; $display("FAIL load_ar_count got %0d expected 1", ar_hs - a0); end
    endtask

    task automatic test_store_delayed_aw();
        int aw0, w0;
        aw0 = aw_hs; w0 = w_hs;
        aw_delay = 3;
        dmem_addr = 32'h0000_2000; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'b0011; dmem_wen = 1'b1;
        step(); // cycle 1
        checks++; if ({AWVALID, WVALID, WLAST, AWLEN, AWSIZE, AWBURST} !== {1'b1, 1'b1, 1'b1, 4'd0, 3'd2, 2'b01}) begin errors++; $display("FAIL store_c1 fields got %b", {AWVALID, WVALID, WLAST, AWLEN, AWSIZE, AWBURST}); end
        checks++; if ({WDATA, WSTRB} !== {32'h1234_5678, 4'b0011}) begin errors++; $display("FAIL store_wdata got %h/%b expected 12345678/0011", WDATA, WSTRB); end
        step(); // cycle 2
        dmem_addr = 32'hFFFF_0000; dmem_wdata = 32'h0;
        checks++; if ({AWVALID, WVALID, BREADY, stall_o} !== 4'b1001) begin errors++; $display("FAIL store_c2 aw/w/b/stall got %b expected 1001", {AWVALID, WVALID, BREADY, stall_o}); end
        step(); // cycle 3
        checks++; if (AWADDR !== 32'h0000_2000) begin errors++; $display("FAIL store_awaddr_held got %h expected 00002000", AWADDR); end
        step(); // cycle 4: AWREADY now
        checks++; if ({AWVALID, AWREADY, BREADY, stall_o} !== 4'b1101) begin errors++; $display("FAIL store_c4 got %b expected 1101", {AWVALID, AWREADY, BREADY, stall_o}); end
        step(); // cycle 5: WR_RESP
        checks++; if ({AWVALID, WVALID, BREADY, stall_o} !== 4'b0011) begin errors++; $display("FAIL store_c5 got %b expected 0011", {AWVALID, WVALID, BREADY, stall_o}); end
        step(); // cycle 6: DONE
        checks++; if ({stall_o, BREADY, err_o} !== 3'b000) begin errors++; $display("FAIL store_done got %b expected 000", {stall_o, BREADY, err_o}); end
        checks++; if (dmem_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_rdata_kept got %h expected deadbeef", dmem_rdata); end
        checks++; if ({aw_hs - aw0, w_hs - w0} !== {32'd1, 32'd1}) begin errors++; $display("FAIL store_hs_counts got %0d/%0d expected 1/1", aw_hs - aw0, w_hs - w0); end
        dmem_wen = 1'b0; aw_delay = 0;
        step();
    endtask

    task automatic test_simultaneous();
        int a0, aw0, w0, n;
        a0 = ar_hs; aw0 = aw_hs; w0 = w_hs; n = 0;
        dmem_addr = 32'h0000_3000; dmem_wdata = 32'h0BAD_F00D; dmem_wstrb = 4'hF;
        dmem_ren = 1'b1; dmem_wen = 1'b1;
        step(); n = 1;
        while (stall_o && n < 20) begin step(); n++; end
        checks++; if (n !== 3) begin errors++; $display("FAIL simul_latency got %0d expected 3", n); end
        dmem_ren = 1'b0; dmem_wen = 1'b0;
        step();
        checks++; if ({ar_hs - a0, aw_hs - aw0, w_hs - w0} !== {32'd0, 32'd1, 32'd1}) begin errors++; $display("FAIL simul_counts ar/aw/w got %0d/%0d/%0d expected 0/1/1", ar_hs - a0, aw_hs - aw0, w_hs - w0); end
    endtask

    task automatic test_back_to_back();
        int a0, first;
        a0 = ar_hs;
        s_rdata = 32'h0000_000A; dmem_addr = 32'h0000_0010; dmem_ren = 1'b1;
        repeat (3) step(); // cycle 3: DONE
        checks++; if ({dmem_rdata, ARVALID, stall_o} !== {32'hA, 1'b0, 1'b0}) begin errors++; $display("FAIL b2b_first got %h arv %b stall %b expected a/0/0", dmem_rdata, ARVALID, stall_o); end
        step(); // cycle 4: IDLE with next request
        first = ar_hs_cyc;
        s_rdata = 32'h0000_000B; dmem_addr = 32'h0000_0014;
        checks++; if ({ARVALID, stall_o} !== 2'b01) begin errors++; $display("FAIL b2b_idle got %b expected 01", {ARVALID, stall_o}); end
        step(); // cycle 5
        checks++; if ({ARVALID, ARADDR} !== {1'b1, 32'h14}) begin errors++; $display("FAIL b2b_second_ar got %b/%h expected 1/00000014", ARVALID, ARADDR); end
        step(); // cycle 6
        checks++; if (dmem_rdata !== 32'hA) begin errors++; $display("FAIL b2b_hold got %h expected a", dmem_rdata); end
        step(); // cycle 7
        checks++; if ({dmem_rdata, stall_o} !== {32'hB, 1'b0}) begin errors++; $display("FAIL b2b_second got %h stall %b expected b/0", dmem_rdata, stall_o); end
        dmem_ren = 1'b0;
        step();
        checks++; if ((ar_hs - a0) !== 2 || (ar_hs_cyc - first) !== 4) begin errors++; $display("FAIL b2b_spacing count %0d gap %0d expected 2/4", ar_hs - a0, ar_hs_cyc - first); end
    endtask

    task automatic test_error();
        s_bresp = 2'b10;
        dmem_addr = 32'h0000_0050; dmem_wdata = 32'h0000_CAFE; dmem_wstrb = 4'hF; dmem_wen = 1'b1;
        step(); step(); // cycle 2: WR_RESP
        checks++; if ({BREADY, err_o} !== 2'b10) begin errors++; $display("FAIL err_before got %b expected 10", {BREADY, err_o}); end
        step(); // cycle 3: DONE
        checks++; if ({err_o, stall_o} !== 2'b10) begin errors++; $display("FAIL err_set got %b expected 10", {err_o, stall_o}); end
        dmem_wen = 1'b0; s_bresp = 2'b00;
        step();
        s_rdata = 32'h0000_0011; dmem_addr = 32'h0000_0054; dmem_ren = 1'b1;
        repeat (3) step();
        checks++; if ({dmem_rdata, err_o} !== {32'h11, 1'b1}) begin errors++; $display("FAIL err_sticky got %h/%b expected 00000011/1", dmem_rdata, err_o); end
        dmem_ren = 1'b0;
        step();
    endtask

    task automatic test_reset_midread();
        r_delay = 1000;
        dmem_addr = 32'h0000_0060; dmem_ren = 1'b1;
        step(); step(); // cycle 2: RD_DATA, RVALID withheld
        checks++; if ({RREADY, RVALID, stall_o} !== 3'b101) begin errors++; $display("FAIL rst_mid_pre got %b expected 101", {RREADY, RVALID, stall_o}); end
        #2 ARESETn = 1'b0;
        #1;
        checks++; if ({ARVALID, RREADY, AWVALID, WVALID, BREADY, err_o} !== 6'b0) begin errors++; $display("FAIL rst_mid_outputs got %b expected 000000", {ARVALID, RREADY, AWVALID, WVALID, BREADY, err_o}); end
        dmem_ren = 1'b0; #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rst_mid_idle stall got %b expected 0", stall_o); end
        step();
        ARESETn = 1'b1; r_delay = 0; s_rdata = 32'h0000_55AA;
        step();
        dmem_addr = 32'h0000_0064; dmem_ren = 1'b1;
        step();
        checks++; if ({ARVALID, ARADDR} !== {1'b1, 32'h64}) begin errors++; $display("FAIL rst_mid_reload_ar got %b/%h expected 1/00000064", ARVALID, ARADDR); end
        step(); step();
        checks++; if ({dmem_rdata, stall_o} !== {32'h55AA, 1'b0}) begin errors++; $display("FAIL rst_mid_reload got %h stall %b expected 000055aa/0", dmem_rdata, stall_o); end
        dmem_ren = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_load();
        test_store_delayed_aw();
        test_simultaneous();
        test_back_to_back();
        test_error();
        test_reset_midread();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
